// File: rtl/sram_like_responder.sv
// SRAM-like data-port slave: accepts requests, issues them to a synchronous RAM,
// and returns in-order responses a fixed LATENCY cycles after acceptance.
module sram_like_responder #(
  parameter int LATENCY = 2,
  parameter int DEPTH   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic        ram_en,
  output logic [3:0]  ram_wen,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [CW-1:0]      cnt_reg;
  logic [LATENCY-1:0] valid_reg;
  logic [LATENCY-1:0] wr_reg;
  logic [31:0]        resp_data;
  logic               accept;

  // A response leaving this cycle frees a slot, so a full pipe can still accept.
  assign data_data_ok = valid_reg[LATENCY-1];
  assign data_addr_ok = data_req && ((cnt_reg < DEPTH_C) || data_data_ok);
  assign accept       = data_req && data_addr_ok;

  assign ram_en    = accept;
  assign ram_addr  = {data_addr[31:2], 2'b00};
  assign ram_wdata = data_wdata;

  always_comb begin
    ram_wen = 4'b0000;
    if (accept && data_wr) begin
      case (data_size)
        2'd0:    ram_wen = 4'b0001 << data_addr[1:0];
        2'd1:    ram_wen = data_addr[1] ? 4'b1100 : 4'b0011;
        default: ram_wen = 4'b1111;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg   <= '0;
      valid_reg <= '0;
      wr_reg    <= '0;
    end else begin
      case ({accept, data_data_ok})
        2'b10:   cnt_reg <= cnt_reg + 1'b1;
        2'b01:   cnt_reg <= cnt_reg - 1'b1;
        default: cnt_reg <= cnt_reg;
      endcase
      valid_reg[0] <= accept;
      wr_reg[0]    <= data_wr;
      for (int i = 1; i < LATENCY; i++) begin
        valid_reg[i] <= valid_reg[i-1];
        wr_reg[i]    <= wr_reg[i-1];
      end
    end
  end

  // RAM read data lands one cycle after issue; deeper pipes carry it forward.
  generate
    if (LATENCY == 1) begin : gen_comb
      assign resp_data = ram_rdata;
    end else begin : gen_pipe
      logic [31:0] data_reg [LATENCY-1];
      for (genvar gi = 0; gi < LATENCY - 1; gi++) begin : gen_stage
        always_ff @(posedge clk or posedge reset) begin
          if (reset) begin
            data_reg[gi] <= '0;
          end else if (gi == 0) begin
            data_reg[gi] <= ram_rdata;
          end else begin
            data_reg[gi] <= data_reg[(gi == 0) ? 0 : gi - 1];
          end
        end
      end
      assign resp_data = data_reg[LATENCY-2];
    end
  endgenerate

  assign data_rdata = (data_data_ok && !wr_reg[LATENCY-1]) ? resp_data : 32'h0;

endmodule

// File: tb/tb_sram_like_responder.sv
// Directed bench for sram_like_responder: three configurations (L2/D2, L3/D2, L1/D1)
// share stimulus, each backed by its own byte-writable synchronous RAM.
module tb_sram_like_responder;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        req   = 1'b0;
  logic        wr    = 1'b0;
  logic [1:0]  size  = 2'd0;
  logic [31:0] addr  = 32'h0;
  logic [31:0] wdata = 32'h0;

  logic [2:0]        addr_ok;
  logic [2:0]        data_ok;
  logic [2:0]        ram_en;
  logic [2:0][3:0]   ram_wen;
  logic [2:0][31:0]  rdata;
  logic [2:0][31:0]  ram_addr;
  logic [2:0][31:0]  ram_wdata;

  int checks = 0;
  int errors = 0;

  localparam logic [0:10] AOK = 11'b11011010000;
  localparam logic [0:10] DOK = 11'b00011011010;
  localparam logic [31:0] BV [8] = '{32'h0123_4567, 32'h89AB_CDEF, 32'h1357_9BDF, 32'h2468_ACE0,
                                     32'hF0E1_D2C3, 32'h5A5A_A5A5, 32'h0000_0001, 32'h8000_0000};

  always #5 clk = ~clk;

  // Instance 0: L2/D2, instance 1: L3/D2, instance 2: L1/D1
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      logic [31:0] mem [256];
      logic [31:0] ram_rdata;

      sram_like_responder #(
        .LATENCY((gi == 0) ? 2 : (gi == 1) ? 3 : 1),
        .DEPTH  ((gi == 2) ? 1 : 2)
      ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .data_req    (req),
        .data_wr     (wr),
        .data_size   (size),
        .data_addr   (addr),
        .data_wdata  (wdata),
        .data_rdata  (rdata[gi]),
        .data_addr_ok(addr_ok[gi]),
        .data_data_ok(data_ok[gi]),
        .ram_en      (ram_en[gi]),
        .ram_wen     (ram_wen[gi]),
        .ram_addr    (ram_addr[gi]),
        .ram_wdata   (ram_wdata[gi]),
        .ram_rdata   (ram_rdata)
      );

      always @(posedge clk) begin
        if (ram_en[gi]) begin
          for (int b = 0; b < 4; b++)
            if (ram_wen[gi][b]) mem[ram_addr[gi][9:2]][8*b +: 8] <= ram_wdata[gi][8*b +: 8];
          ram_rdata <= mem[ram_addr[gi][9:2]];
        end
      end
    end
  endgenerate

  // Drive one cycle of inputs at the falling edge, then settle before checking.
  task automatic set_in(input logic r, input logic w, input logic [1:0] s,
                        input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    req = r; wr = w; size = s; addr = a; wdata = d;
    #1;
    if (r) $display("txn t=%0t %s size=%0d addr=%h wdata=%h", $time, w ? "WR" : "RD", s, a, d);
  endtask

  task automatic drain();
    repeat (4) set_in(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
  endtask

  task automatic test_reset();
    @(negedge clk); #1;
    checks++;
    if (data_ok !== 3'b000 || ram_en !== 3'b000) begin
      errors++; $display("FAIL in_reset data_ok=%b ram_en=%b exp 000", data_ok, ram_en);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      set_in(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
      checks++;
      if (addr_ok !== 3'b000) begin errors++; $display("FAIL idle_addr_ok got %b exp 000", addr_ok); end
      checks++;
      if (data_ok !== 3'b000) begin errors++; $display("FAIL idle_data_ok got %b exp 000", data_ok); end
      checks++;
      if (ram_en !== 3'b000) begin errors++; $display("FAIL idle_ram_en got %b exp 000", ram_en); end
      checks++;
      if (rdata !== '0 || ram_wen !== '0) begin
        errors++; $display("FAIL idle_rdata_wen got %h/%h exp 0", rdata, ram_wen);
      end
    end
    $display("test_reset done");
  endtask

  task automatic test_write_read();
    set_in(1'b1, 1'b1, 2'd2, 32'h100, 32'hDEAD_BEEF);
    checks++;
    if (addr_ok[0] !== 1'b1 || ram_en[0] !== 1'b1) begin
      errors++; $display("FAIL wr_accept addr_ok=%b ram_en=%b exp 1/1", addr_ok[0], ram_en[0]);
    end
    checks++;
    if (ram_wen[0] !== 4'hF) begin errors++; $display("FAIL wr_wen got %b exp 1111", ram_wen[0]); end
    checks++;
    if (ram_addr[0] !== 32'h100 || ram_wdata[0] !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL wr_ram_bus got %h/%h exp 00000100/deadbeef", ram_addr[0], ram_wdata[0]);
    end
    set_in(1'b1, 1'b0, 2'd2, 32'h100, 32'h0);
    checks++;
    if (addr_ok[0] !== 1'b1 || ram_wen[0] !== 4'h0) begin
      errors++; $display("FAIL rd_accept addr_ok=%b wen=%b exp 1/0000", addr_ok[0], ram_wen[0]);
    end
    checks++;
    if (data_ok[0] !== 1'b0) begin errors++; $display("FAIL early_data_ok got %b exp 0", data_ok[0]); end
    set_in(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    checks++;
    if (data_ok[0] !== 1'b1 || rdata[0] !== 32'h0) begin
      errors++; $display("FAIL wr_resp data_ok=%b rdata=%h exp 1/00000000", data_ok[0], rdata[0]);
    end
    set_in(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    checks++;
    if (data_ok[0] !== 1'b1 || rdata[0] !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL rd_resp data_ok=%b rdata=%h exp 1/deadbeef", data_ok[0], rdata[0]);
    end
    set_in(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    checks++;
    if (data_ok[0] !== 1'b0) begin errors++; $display("FAIL resp_end got %b exp 0", data_ok[0]); end
    drain();
    $display("test_write_read done");
  endtask

  task automatic test_wen();
    logic        tw [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [1:0]  ts [6] = '{2'd0, 2'd1, 2'd3, 2'd1, 2'd0, 2'd2};
    logic [31:0] ta [6] = '{32'h103, 32'h102, 32'h100, 32'h101, 32'h101, 32'h100};
    logic [3:0]  te [6] = '{4'b1000, 4'b1100, 4'b1111, 4'b0011, 4'b0010, 4'b0000};
    for (int i = 0; i < 6; i++) begin
      set_in(1'b1, tw[i], ts[i], ta[i], 32'hAAAA_AAAA);
      checks++;
      if (addr_ok[0] !== 1'b1 || ram_wen[0] !== te[i]) begin
        errors++; $display("FAIL wen_%0d addr_ok=%b wen=%b exp 1/%b", i, addr_ok[0], ram_wen[0], te[i]);
      end
      checks++;
      if (ram_addr[0] !== 32'h100) begin
        errors++; $display("FAIL wen_addr_%0d got %h exp 00000100", i, ram_addr[0]);
      end
    end
    drain();
    $display("test_wen done");
  endtask

  task automatic test_throughput();
    for (int k = 0; k < 11; k++) begin
      set_in(k < 7, 1'b0, 2'd2, 32'h0, 32'h0);
      checks++;
      if (addr_ok[1] !== AOK[k] || ram_en[1] !== AOK[k]) begin
        errors++; $display("FAIL tp_accept_%0d addr_ok=%b ram_en=%b exp %b", k, addr_ok[1], ram_en[1], AOK[k]);
      end
      checks++;
      if (data_ok[1] !== DOK[k]) begin
        errors++; $display("FAIL tp_data_ok_%0d got %b exp %b", k, data_ok[1], DOK[k]);
      end
    end
    drain();
    $display("test_throughput done");
  endtask

  task automatic test_reset_midflight();
    set_in(1'b1, 1'b0, 2'd2, 32'h100, 32'h0);
    checks++;
    if (addr_ok[0] !== 1'b1) begin errors++; $display("FAIL mf_accept got %b exp 1", addr_ok[0]); end
    @(negedge clk);
    req = 1'b0; reset = 1'b1;
    #1;
    checks++;
    if (data_ok[0] !== 1'b0) begin errors++; $display("FAIL mf_in_reset got %b exp 0", data_ok[0]); end
    @(negedge clk);
    reset = 1'b0; req = 1'b1; wr = 1'b0; addr = 32'h100;
    #1;
    checks++;
    if (data_ok[0] !== 1'b0) begin errors++; $display("FAIL mf_discard got %b exp 0", data_ok[0]); end
    checks++;
    if (addr_ok[0] !== 1'b1) begin errors++; $display("FAIL mf_post_accept got %b exp 1", addr_ok[0]); end
    set_in(1'b1, 1'b0, 2'd2, 32'h100, 32'h0);
    checks++;
    if (addr_ok[0] !== 1'b1 || data_ok[0] !== 1'b0) begin
      errors++; $display("FAIL mf_cnt_clear addr_ok=%b data_ok=%b exp 1/0", addr_ok[0], data_ok[0]);
    end
    set_in(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    checks++;
    if (data_ok[0] !== 1'b1 || rdata[0] !== 32'hAAAA_AAAA) begin
      errors++; $display("FAIL mf_resp1 data_ok=%b rdata=%h exp 1/aaaaaaaa", data_ok[0], rdata[0]);
    end
    set_in(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    checks++;
    if (data_ok[0] !== 1'b1 || rdata[0] !== 32'hAAAA_AAAA) begin
      errors++; $display("FAIL mf_resp2 data_ok=%b rdata=%h exp 1/aaaaaaaa", data_ok[0], rdata[0]);
    end
    drain();
    $display("test_reset_midflight done");
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 18; k++) begin
      if (k < 8)       set_in(1'b1, 1'b1, 2'd2, 32'h200 + 32'(4 * k), BV[k]);
      else if (k < 16) set_in(1'b1, 1'b0, 2'd2, 32'h200 + 32'(4 * (k - 8)), 32'h0);
      else             set_in(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
      checks++;
      if (addr_ok[2] !== (k < 16)) begin
        errors++; $display("FAIL b2b_addr_ok_%0d got %b exp %b", k, addr_ok[2], (k < 16));
      end
      checks++;
      if (data_ok[2] !== (k >= 1 && k <= 16)) begin
        errors++; $display("FAIL b2b_data_ok_%0d got %b exp %b", k, data_ok[2], (k >= 1 && k <= 16));
      end
      if (k >= 1 && k <= 8) begin
        checks++;
        if (rdata[2] !== 32'h0) begin errors++; $display("FAIL b2b_wr_rdata_%0d got %h exp 0", k, rdata[2]); end
      end else if (k >= 9 && k <= 16) begin
        checks++;
        if (rdata[2] !== BV[k-9]) begin
          errors++; $display("FAIL b2b_rdata_%0d got %h exp %h", k, rdata[2], BV[k-9]);
        end
      end
    end
    $display("test_back_to_back done");
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_wen();
    test_throughput();
    test_reset_midflight();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
